// File: rtl/i2c_register_bank.sv
// Register bank behind the i2c_peripheral read/write handshake: R/W control registers plus RO status inputs.
// Optional feature macro I2C_REGBANK_ERR_CNT_EN maps a saturating illegal-access counter at address NUM_REGS.
module i2c_register_bank #(
  parameter int         NUM_REGS    = 16,
  parameter int         RO_BASE     = 12,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic                            i_sys_clk,
  input  logic                            i_rst,
  input  logic [7:0]                      i_register_address,
  input  logic                            i_read_enable,
  output logic [7:0]                      o_register_data,
  output logic                            o_read_valid,
  input  logic                            i_read_ack,
  input  logic [7:0]                      i_register_data,
  input  logic                            i_write_valid,
  output logic                            o_write_ack,
  output logic [8*RO_BASE-1:0]            o_regs,
  input  logic [8*(NUM_REGS-RO_BASE)-1:0] i_status,
  output logic                            o_wr_strobe,
  output logic [7:0]                      o_wr_index
);

  localparam int         NUM_RO      = NUM_REGS - RO_BASE;
  localparam logic [7:0] LP_RO_BASE  = 8'(RO_BASE);
  localparam logic [7:0] LP_NUM_REGS = 8'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_VALID,
    ST_RD_RELEASE,
    ST_WR_ACK
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [8*RO_BASE-1:0] r_regs;
  logic [7:0]          r_register_data;
  logic                r_read_valid;
  logic                r_write_ack;
  logic                r_wr_strobe;
  logic [7:0]          r_wr_index;
  logic                w_commit;
  logic                w_capture;
  logic                w_wr_done;
  logic                w_rd_acked;
  logic                w_addr_rw;
  logic [7:0]          w_read_data;

`ifdef I2C_REGBANK_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_clr;
  logic       w_err_inc;
`endif

  assign w_addr_rw = (i_register_address < LP_RO_BASE);

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_capture    = 1'b0;
    w_wr_done    = 1'b0;
    w_rd_acked   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A pending write always beats a simultaneous read request.
        if (i_write_valid) begin
          w_commit     = 1'b1;
          w_state_next = ST_WR_ACK;
        end else if (i_read_enable) begin
          w_capture    = 1'b1;
          w_state_next = ST_RD_VALID;
        end
      end
      ST_RD_VALID: begin
        if (i_read_ack) begin
          w_rd_acked   = 1'b1;
          w_state_next = ST_RD_RELEASE;
        end
      end
      ST_RD_RELEASE: begin
        if (!i_read_enable) w_state_next = ST_IDLE;
      end
      ST_WR_ACK: begin
        if (!i_write_valid) begin
          w_wr_done    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_read_data = 8'h00;
    for (int k = 0; k < RO_BASE; k++) begin
      if (i_register_address == 8'(k)) w_read_data = r_regs[8*k +: 8];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (i_register_address == 8'(RO_BASE + k)) w_read_data = i_status[8*k +: 8];
    end
`ifdef I2C_REGBANK_ERR_CNT_EN
    if (i_register_address == LP_NUM_REGS) w_read_data = r_err_cnt;
`endif
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_register_data <= 8'h00;
      r_read_valid    <= 1'b0;
      r_write_ack     <= 1'b0;
      r_wr_strobe     <= 1'b0;
      r_wr_index      <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_wr_strobe <= w_commit && w_addr_rw;
      if (w_commit) begin
        r_write_ack <= 1'b1;
        if (w_addr_rw) r_wr_index <= i_register_address;
      end else if (w_wr_done) begin
        r_write_ack <= 1'b0;
      end
      if (w_capture) begin
        r_register_data <= w_read_data;
        r_read_valid    <= 1'b1;
      end else if (w_rd_acked) begin
        r_read_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_regs <= {RO_BASE{RESET_VALUE}};
    end else if (w_commit) begin
      for (int k = 0; k < RO_BASE; k++) begin
        if (i_register_address == 8'(k)) r_regs[8*k +: 8] <= i_register_data;
      end
    end
  end

`ifdef I2C_REGBANK_ERR_CNT_EN
  // Writes to RO/unmapped space and reads past the counter are illegal; a counter write clears it.
  assign w_err_clr = w_commit && (i_register_address == LP_NUM_REGS);
  assign w_err_inc = (w_commit && !w_addr_rw && (i_register_address != LP_NUM_REGS)) ||
                     (w_capture && (i_register_address > LP_NUM_REGS));

  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_clr) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end
`endif

  assign o_register_data = r_register_data;
  assign o_read_valid    = r_read_valid;
  assign o_write_ack     = r_write_ack;
  assign o_regs          = r_regs;
  assign o_wr_strobe     = r_wr_strobe;
  assign o_wr_index      = r_wr_index;

endmodule

// File: tb/tb_i2c_register_bank.sv
// Self-checking bench for i2c_register_bank: directed handshake scenarios plus randomized traffic
// against an array-based reference model (counter scenarios only when I2C_REGBANK_ERR_CNT_EN is defined).
module tb_i2c_register_bank;

  localparam int         NUM_REGS    = 16;
  localparam int         RO_BASE     = 12;
  localparam int         NUM_RO      = NUM_REGS - RO_BASE;
  localparam logic [7:0] RESET_VALUE = 8'h00;

  logic                   i_sys_clk = 1'b0;
  logic                   i_rst;
  logic [7:0]             i_register_address;
  logic                   i_read_enable;
  logic [7:0]             o_register_data;
  logic                   o_read_valid;
  logic                   i_read_ack;
  logic [7:0]             i_register_data;
  logic                   i_write_valid;
  logic                   o_write_ack;
  logic [8*RO_BASE-1:0]   o_regs;
  logic [8*NUM_RO-1:0]    i_status;
  logic                   o_wr_strobe;
  logic [7:0]             o_wr_index;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mRw [RO_BASE];
  logic [7:0] mIndex;
  int         mErr;

  i2c_register_bank #(
    .NUM_REGS    (NUM_REGS),
    .RO_BASE     (RO_BASE),
    .RESET_VALUE (RESET_VALUE)
  ) dut (
    .i_sys_clk          (i_sys_clk),
    .i_rst              (i_rst),
    .i_register_address (i_register_address),
    .i_read_enable      (i_read_enable),
    .o_register_data    (o_register_data),
    .o_read_valid       (o_read_valid),
    .i_read_ack         (i_read_ack),
    .i_register_data    (i_register_data),
    .i_write_valid      (i_write_valid),
    .o_write_ack        (o_write_ack),
    .o_regs             (o_regs),
    .i_status           (i_status),
    .o_wr_strobe        (o_wr_strobe),
    .o_wr_index         (o_wr_index)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wv, input logic re, input logic ra,
                               input int addr, input logic [7:0] data);
    i_write_valid      = wv;
    i_read_enable      = re;
    i_read_ack         = ra;
    i_register_address = 8'(addr);
    i_register_data    = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*RO_BASE-1:0] expRegs();
    logic [8*RO_BASE-1:0] v;
    for (int k = 0; k < RO_BASE; k++) v[8*k +: 8] = mRw[k];
    return v;
  endfunction

  task automatic checkRegs(input string tag);
    logic [8*RO_BASE-1:0] exp;
    exp = expRegs();
    checks++;
    assert (o_regs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, o_regs, exp);
    end
  endtask

  function automatic logic [7:0] expRead(input int addr);
    if (addr < RO_BASE) return mRw[addr];
    if (addr < NUM_REGS) return i_status[8*(addr-RO_BASE) +: 8];
`ifdef I2C_REGBANK_ERR_CNT_EN
    if (addr == NUM_REGS) return 8'(mErr);
`endif
    return 8'h00;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < RO_BASE; k++) mRw[k] = RESET_VALUE;
    mIndex = 8'h00;
    mErr   = 0;
  endtask

  task automatic bumpErr();
    if (mErr < 255) mErr++;
  endtask

  // Full four-phase write: ack one cycle after valid, then release.
  task automatic writeTxn(input int addr, input logic [7:0] data);
    logic rw;
    rw = (addr < RO_BASE);
    applyStimulus(1'b1, 1'b0, 1'b0, addr, data);
    tick();
    if (rw) begin
      mRw[addr] = data;
      mIndex    = 8'(addr);
    end
`ifdef I2C_REGBANK_ERR_CNT_EN
    if (addr == NUM_REGS) mErr = 0;
    else if (!rw) bumpErr();
`endif
    checkOutput("wr_ack_rise", 32'(o_write_ack), 32'd1);
    checkOutput("wr_strobe", 32'(o_wr_strobe), 32'(rw));
    checkOutput("wr_index", 32'(o_wr_index), 32'(mIndex));
    checkRegs("wr_regs");
    applyStimulus(1'b0, 1'b0, 1'b0, addr, data);
    tick();
    checkOutput("wr_ack_fall", 32'(o_write_ack), 32'd0);
    checkOutput("wr_strobe_once", 32'(o_wr_strobe), 32'd0);
  endtask

  task automatic readTxn(input int addr);
    logic [7:0] exp;
    exp = expRead(addr);
    applyStimulus(1'b0, 1'b1, 1'b0, addr, 8'h00);
    tick();
    checkOutput("rd_valid", 32'(o_read_valid), 32'd1);
    checkOutput("rd_data", 32'(o_register_data), 32'(exp));
`ifdef I2C_REGBANK_ERR_CNT_EN
    if (addr > NUM_REGS) bumpErr();
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, addr, 8'h00);
    tick();
    checkOutput("rd_valid_drop", 32'(o_read_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, addr, 8'h00);
    tick();
    checkOutput("rd_data_hold", 32'(o_register_data), 32'(exp));
  endtask

  initial begin
    int cnt;
    int acks;
    int addr;
    i_rst    = 1'b1;
    i_status = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
    modelReset();
    tick();
    tick();
    checkOutput("rst_data", 32'(o_register_data), 32'd0);
    checkOutput("rst_valid", 32'(o_read_valid), 32'd0);
    checkOutput("rst_ack", 32'(o_write_ack), 32'd0);
    checkOutput("rst_strobe", 32'(o_wr_strobe), 32'd0);
    checkOutput("rst_index", 32'(o_wr_index), 32'd0);
    checkRegs("rst_regs");
    i_rst = 1'b0;
    tick();

    $display("[TB] basic write/read");
    writeTxn(5, 8'hAA);
    checkOutput("reg5_byte", 32'(o_regs[47:40]), 32'h0000_00AA);
    readTxn(5);

    $display("[TB] status and read-only space");
    i_status = {8'($urandom), 8'($urandom), 8'($urandom), 8'h3C};
    readTxn(12);
    writeTxn(12, 8'h11);
    readTxn(12);
    readTxn(8'h40);

    $display("[TB] simultaneous write and read");
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 8'h77);
    tick();
    mRw[2] = 8'h77;
    mIndex = 8'h02;
    checkOutput("both_ack", 32'(o_write_ack), 32'd1);
    checkOutput("both_no_valid", 32'(o_read_valid), 32'd0);
    checkOutput("both_strobe", 32'(o_wr_strobe), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2, 8'h00);
    tick();
    checkOutput("both_ack_drop", 32'(o_write_ack), 32'd0);
    checkOutput("both_wait_valid", 32'(o_read_valid), 32'd0);
    tick();
    checkOutput("both_rd_valid", 32'(o_read_valid), 32'd1);
    checkOutput("both_rd_data", 32'(o_register_data), 32'h77);
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 2, 8'h00);
    tick();

    $display("[TB] held enables");
    applyStimulus(1'b0, 1'b1, 1'b0, 5, 8'h00);
    tick();
    checkOutput("held_rd_valid", 32'(o_read_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 5, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 5, 8'h00);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_read_valid) cnt++;
    end
    checkOutput("held_rd_no_repeat", 32'(cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5, 8'h00);
    tick();
    readTxn(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 4, 8'h42);
    cnt  = 0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_wr_strobe) cnt++;
      if (o_write_ack) acks++;
    end
    mRw[4] = 8'h42;
    mIndex = 8'h04;
    checkOutput("held_wr_strobes", 32'(cnt), 32'd1);
    checkOutput("held_wr_acks", 32'(acks), 32'd10);
    checkRegs("held_wr_regs");
    applyStimulus(1'b0, 1'b0, 1'b0, 4, 8'h00);
    tick();
    checkOutput("held_wr_release", 32'(o_write_ack), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) i_status = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      if ($urandom_range(0, 3) == 0) addr = int'($urandom_range(0, 255));
      else addr = int'($urandom_range(0, NUM_REGS + 3));
      if ($urandom_range(0, 1) == 1) writeTxn(addr, 8'($urandom));
      else readTxn(addr);
    end

    $display("[TB] reset mid-transaction");
    writeTxn(5, 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b0, 5, 8'h00);
    tick();
    checkOutput("rst_rd_pre_valid", 32'(o_read_valid), 32'd1);
    i_rst = 1'b1;
    tick();
    modelReset();
    checkOutput("rst_rd_valid", 32'(o_read_valid), 32'd0);
    checkOutput("rst_rd_data", 32'(o_register_data), 32'd0);
    checkOutput("rst_rd_index", 32'(o_wr_index), 32'd0);
    checkRegs("rst_rd_regs");
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 8'h5A);
    tick();
    checkOutput("rst_wr_pre_ack", 32'(o_write_ack), 32'd1);
    i_rst = 1'b1;
    tick();
    checkOutput("rst_wr_ack", 32'(o_write_ack), 32'd0);
    checkOutput("rst_wr_strobe", 32'(o_wr_strobe), 32'd0);
    checkOutput("rst_wr_index", 32'(o_wr_index), 32'd0);
    checkRegs("rst_wr_regs");
    applyStimulus(1'b1, 1'b0, 1'b0, 7, 8'h99);
    tick();
    checkOutput("rst_nocommit_ack", 32'(o_write_ack), 32'd0);
    checkOutput("rst_nocommit_strobe", 32'(o_wr_strobe), 32'd0);
    checkRegs("rst_nocommit_regs");
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
    tick();
    readTxn(7);
    readTxn(3);

`ifdef I2C_REGBANK_ERR_CNT_EN
    $display("[TB] error counter");
    writeTxn(NUM_REGS, 8'h00);
    for (int i = 0; i < 3; i++) writeTxn(8'h0D, 8'($urandom));
    readTxn(8'h20);
    readTxn(NUM_REGS);
    checkOutput("err_cnt_four", 32'(o_register_data), 32'd4);
    writeTxn(NUM_REGS, 8'h5C);
    readTxn(NUM_REGS);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) writeTxn(8'h0E, 8'($urandom));
      else readTxn(8'h80);
    end
    readTxn(NUM_REGS);
    checkOutput("err_cnt_sat", 32'(o_register_data), 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
